// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus responder: request order encodings, bus widths
// and the byte-lane decode used by line writes.
package mem_bus_pkg;

    localparam int unsigned LINE_W = 64;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ORDER_BYTE = 2'b00,
        ORDER_HALF = 2'b01,
        ORDER_WORD = 2'b10,
        ORDER_NONE = 2'b11
    } order_e;

    // Bit b enables line bits [8b+7:8b]; byte offset 0 is the most significant byte.
    function automatic logic [7:0] line_byte_en(input logic [1:0] order, input logic [2:0] offset);
        logic [7:0] be;
        be = '0;
        case (order)
            ORDER_BYTE: be = 8'b1000_0000 >> offset;
            ORDER_HALF: be = 8'b1100_0000 >> {offset[2:1], 1'b0};
            ORDER_WORD: be = offset[2] ? 8'h0F : 8'hF0;
            default:    be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_bus_resp_fifo.sv
// Synchronous response FIFO for the memory bus responder; head is visible combinationally
// from the read pointer.
module mem_bus_resp_fifo #(
    parameter int unsigned P_DEPTH = 4,
    parameter int unsigned P_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [P_WIDTH-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(P_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(P_DEPTH - 1);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(P_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_latency_model.sv
// Memory-side responder: line RAM with byte/half/word writes and line reads returned after a
// fixed latency. Define MEM_BUS_RANDOM_LOCK_EN to add LFSR-driven random request stalls.
module mem_bus_latency_model #(
    parameter int unsigned P_DEPTH_LINES = 16384,
    parameter int unsigned P_LATENCY     = 4,
    parameter int unsigned P_RESP_DEPTH  = 4,
    parameter string       P_INIT_FILE   = ""
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iMEMORY_REQ,
    output logic        oMEMORY_LOCK,
    input  logic [1:0]  iMEMORY_ORDER,
    input  logic        iMEMORY_RW,
    input  logic [31:0] iMEMORY_ADDR,
    input  logic [31:0] iMEMORY_DATA,
    output logic        oMEMORY_VALID,
    input  logic        iMEMORY_BUSY,
    output logic [63:0] oMEMORY_DATA
);

    import mem_bus_pkg::*;

    localparam int unsigned IDX_W = $clog2(P_DEPTH_LINES);
    localparam int unsigned CNT_W = $clog2(P_RESP_DEPTH + 1);

    logic [LINE_W-1:0] ram [P_DEPTH_LINES];
    logic [IDX_W-1:0]  idx;
    logic [7:0]        be;
    logic [LINE_W-1:0] wline;
    logic              accept;
    logic              active;
    logic              wr_en;
    logic              rd_en;

    logic [P_LATENCY-1:0] pipe_vld;
    logic [LINE_W-1:0]    pipe_data [P_LATENCY];
    logic [CNT_W-1:0]     out_cnt_q;
    logic [CNT_W-1:0]     out_cnt_d;
    logic                 lock_q;

    logic              fifo_empty;
    logic              unused_fifo_full;
    logic [LINE_W-1:0] fifo_head;
    logic              pop;

    assign accept = iMEMORY_REQ && !oMEMORY_LOCK;
    assign active = (iMEMORY_ORDER != ORDER_NONE);
    assign wr_en  = accept && active && iMEMORY_RW;
    assign rd_en  = accept && active && !iMEMORY_RW;
    assign idx    = iMEMORY_ADDR[3 +: IDX_W];
    assign be     = line_byte_en(iMEMORY_ORDER, iMEMORY_ADDR[2:0]);

    // Address bits above the RAM size are dropped so accesses alias onto the lower lines.
    if (IDX_W < 29) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^iMEMORY_ADDR[31:3+IDX_W];
    end

    always_comb begin
        wline = {2{iMEMORY_DATA}};
        case (iMEMORY_ORDER)
            ORDER_BYTE: wline = {8{iMEMORY_DATA[7:0]}};
            ORDER_HALF: wline = {4{iMEMORY_DATA[15:0]}};
            default:    wline = {2{iMEMORY_DATA}};
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    ram[idx][8*b +: 8] <= wline[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (rd_en && !pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!rd_en && pop) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            pipe_vld  <= '0;
            for (int i = 0; i < int'(P_LATENCY); i++) begin
                pipe_data[i] <= '0;
            end
            out_cnt_q <= '0;
            lock_q    <= 1'b0;
        end else begin
            pipe_vld[0] <= rd_en;
            if (rd_en) begin
                pipe_data[0] <= ram[idx];
            end
            for (int i = 1; i < int'(P_LATENCY); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            out_cnt_q <= out_cnt_d;
            // Outstanding reads never exceed the FIFO depth, so the pipe can always push.
            lock_q    <= (out_cnt_d == CNT_W'(P_RESP_DEPTH));
        end
    end

`ifdef MEM_BUS_RANDOM_LOCK_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign oMEMORY_LOCK = lock_q || (lfsr_q[1:0] == 2'b00);
`else
    assign oMEMORY_LOCK = lock_q;
`endif

    mem_bus_resp_fifo #(
        .P_DEPTH (P_RESP_DEPTH),
        .P_WIDTH (LINE_W)
    ) u_resp_fifo (
        .clk       (iCLOCK),
        .rst       (iRESET),
        .push      (pipe_vld[P_LATENCY-1]),
        .push_data (pipe_data[P_LATENCY-1]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (unused_fifo_full),
        .empty     (fifo_empty)
    );

    assign oMEMORY_VALID = !fifo_empty;
    assign pop           = oMEMORY_VALID && !iMEMORY_BUSY;
    assign oMEMORY_DATA  = oMEMORY_VALID ? fifo_head : '0;

endmodule

// File: tb/tb_mem_bus_latency_model.sv
// Directed bench for mem_bus_latency_model; exact LOCK timing is only checked when
// MEM_BUS_RANDOM_LOCK_EN is undefined.
module tb_mem_bus_latency_model;

    logic        clk;
    logic        rst;
    logic        req;
    logic        lock;
    logic [1:0]  order;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        valid;
    logic        busy;
    logic [63:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] resp_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] model [8];

    mem_bus_latency_model dut (
        .iCLOCK        (clk),
        .iRESET        (rst),
        .iMEMORY_REQ   (req),
        .oMEMORY_LOCK  (lock),
        .iMEMORY_ORDER (order),
        .iMEMORY_RW    (rw),
        .iMEMORY_ADDR  (addr),
        .iMEMORY_DATA  (wdata),
        .oMEMORY_VALID (valid),
        .iMEMORY_BUSY  (busy),
        .oMEMORY_DATA  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A response is taken at the next rising edge when VALID && !BUSY at the falling edge.
    always @(negedge clk) begin
        if (!rst && valid && !busy) resp_q.push_back(rdata);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds a request until accepted; returns 1 time unit after the accept edge.
    task automatic issue(input logic t_rw, input logic [1:0] t_ord, input logic [31:0] t_addr,
                         input logic [31:0] t_data, input bit rnd_busy);
        bit done;
        done  = 1'b0;
        req   = 1'b1;
        rw    = t_rw;
        order = t_ord;
        addr  = t_addr;
        wdata = t_data;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!lock) done = 1'b1;
            @(posedge clk);
            #1;
            if (rnd_busy) busy = ($urandom_range(0, 2) == 0);
        end
        req = 1'b0;
        if (!done) begin
            errors++;
            $error("FAIL accept_timeout observed=lock_high expected=accept addr=%h", t_addr);
        end
    endtask

    task automatic read_check(input logic [31:0] t_addr, input logic [63:0] exp, input string tag);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        issue(1'b0, 2'b10, t_addr, 32'h0, 1'b0);
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
            else lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk(tag, rdata, exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_wr(input logic [63:0] line, input logic [1:0] ord,
                                             input logic [2:0] off, input logic [31:0] d);
        logic [63:0] r;
        int o;
        r = line;
        o = int'(off);
        case (ord)
            2'b00: r[63-8*o -: 8] = d[7:0];
            2'b01: r[63-8*(o & 6) -: 16] = d[15:0];
            2'b10: r[(o >= 4 ? 31 : 63) -: 32] = d;
            default: r = line;
        endcase
        return r;
    endfunction

    initial begin
        int vseen;
        int waitc;
        logic [2:0]  off;
        logic [1:0]  ord;
        logic        w;
        logic [31:0] d;
        logic [31:0] a;
        int          l;

        rst = 1'b1; req = 1'b0; order = 2'b11; rw = 1'b0; addr = '0; wdata = '0; busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ctl", {62'd0, lock, valid}, 64'd0);
            chk("idle_data", rdata, 64'd0);
        end
        @(posedge clk);
        #1;

        // Word writes through the aliased address, then read back both aliases
        issue(1'b1, 2'b10, 32'h0002_0000, 32'hCAFE_F00D, 1'b0);
        issue(1'b1, 2'b10, 32'h0002_0004, 32'h1122_3344, 1'b0);
        read_check(32'h0002_0000, 64'hCAFEF00D_11223344, "rd_word");
        read_check(32'h0000_0000, 64'hCAFEF00D_11223344, "rd_wrap");

        // Byte and halfword lanes
        issue(1'b1, 2'b10, 32'h0000_0000, 32'h0123_4567, 1'b0);
        issue(1'b1, 2'b10, 32'h0000_0004, 32'h89AB_CDEF, 1'b0);
        issue(1'b1, 2'b00, 32'h0000_0001, 32'hFFFF_FFAB, 1'b0);
        read_check(32'h0000_0000, 64'h01AB4567_89ABCDEF, "rd_byte");
        issue(1'b1, 2'b01, 32'h0000_0006, 32'h1234_BEEF, 1'b0);
        read_check(32'h0000_0004, 64'h01AB4567_89ABBEEF, "rd_half");
        issue(1'b1, 2'b01, 32'h0000_0003, 32'hAAAA_7777, 1'b0);
        issue(1'b1, 2'b00, 32'h0000_0007, 32'h0000_005A, 1'b0);
        read_check(32'h0000_0000, 64'h01AB7777_89ABBE5A, "rd_half_odd_byte7");
        issue(1'b1, 2'b10, 32'h0000_0007, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        read_check(32'h0000_0000, 64'h01AB7777_DEADBEEF, "rd_word_lo_none");

        // Order 11 read produces nothing
        issue(1'b0, 2'b11, 32'h0000_0000, 32'h0, 1'b0);
        vseen = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid) vseen++;
        end
        chk("none_rd_valid", 64'(vseen), 64'd0);
        @(posedge clk);
        #1;

        // Lines 1..5 for the burst and reset tests
        for (int i = 1; i <= 5; i++) begin
            issue(1'b1, 2'b10, 32'(i * 8), 32'hA000_0000 + 32'(i), 1'b0);
            issue(1'b1, 2'b10, 32'(i * 8 + 4), 32'hB000_0000 + 32'(i), 1'b0);
        end

`ifndef MEM_BUS_RANDOM_LOCK_EN
        // Back-pressured burst of five reads
        resp_q.delete();
        busy  = 1'b1;
        req   = 1'b1;
        rw    = 1'b0;
        order = 2'b10;
        for (int i = 0; i < 4; i++) begin
            addr = 32'((i + 1) * 8);
            @(negedge clk);
            chk("burst_lock_pre", {63'd0, lock}, 64'd0);
            @(posedge clk);
            #1;
        end
        addr = 32'd40;
        @(negedge clk);
        chk("burst_lock_full", {63'd0, lock}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("burst_hold_valid", {63'd0, valid}, 64'd1);
        chk("burst_hold_data", rdata, {32'hA000_0001, 32'hB000_0001});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("burst_hold_stable", rdata, {32'hA000_0001, 32'hB000_0001});
        chk("burst_hold_lock", {63'd0, lock}, 64'd1);
        @(posedge clk);
        #1 busy = 1'b0;
        @(negedge clk);
        chk("burst_lock_before_pop", {63'd0, lock}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("burst_lock_after_pop", {63'd0, lock}, 64'd0);
        @(posedge clk);
        #1 req = 1'b0;
        waitc = 0;
        while (resp_q.size() < 5 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        chk("burst_count", 64'(resp_q.size()), 64'd5);
        for (int j = 0; j < 5; j++) begin
            if (j < resp_q.size())
                chk("burst_data", resp_q[j], {32'hA000_0000 + 32'(j + 1), 32'hB000_0000 + 32'(j + 1)});
        end
        repeat (3) @(negedge clk);
        chk("burst_drained", {62'd0, lock, valid}, 64'd0);
        @(posedge clk);
        #1;
`endif

        // Reset with three reads in flight
        busy = 1'b1;
        issue(1'b0, 2'b10, 32'd8, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'd16, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'd24, 32'h0, 1'b0);
        waitc = 0;
        vseen = 0;
        while (vseen == 0 && waitc < 20) begin
            @(negedge clk);
            if (valid) vseen = 1;
            waitc++;
        end
        chk("rst_pre_valid", 64'(vseen), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_valid_now", {63'd0, valid}, 64'd0);
        chk("rst_data_now", rdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        busy = 1'b0;
        resp_q.delete();
        vseen = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) vseen++;
        end
        chk("rst_no_resp", 64'(vseen), 64'd0);
        chk("rst_lock", {63'd0, lock}, 64'd0);
        @(posedge clk);
        #1;
        read_check(32'h0000_0000, 64'h01AB7777_DEADBEEF, "rd_after_rst");

        // Random traffic against a line model
        for (int i = 0; i < 8; i++) begin
            model[i] = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
            issue(1'b1, 2'b10, 32'(i * 8), model[i][63:32], 1'b0);
            issue(1'b1, 2'b10, 32'(i * 8 + 4), model[i][31:0], 1'b0);
        end
        repeat (8) @(posedge clk);
        #1;
        resp_q.delete();
        exp_q.delete();
        for (int n = 0; n < 300; n++) begin
            l   = int'($urandom_range(0, 7));
            off = 3'($urandom_range(0, 7));
            ord = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            a   = ($urandom & 32'hFFFE_0000) | 32'(l << 3) | 32'(off);
            issue(w, ord, a, d, 1'b1);
            if (ord != 2'b11) begin
                if (w) model[l] = model_wr(model[l], ord, off, d);
                else exp_q.push_back(model[l]);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        busy  = 1'b0;
        waitc = 0;
        while (resp_q.size() < exp_q.size() && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        repeat (10) @(negedge clk);
        chk("rnd_count", 64'(resp_q.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j < resp_q.size()) chk("rnd_data", resp_q[j], exp_q[j]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
